// File: rtl/mem_vector_access.sv
// Memory-stage sequencer: splits scalar/vector loads and stores into word beats
// against a synchronous data memory and stalls the pipeline until they complete.
module mem_vector_access #(
  parameter int DATA_W = 192,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              VecOp_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [WORD_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_we,
  output logic              dm_re,
  output logic [WORD_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] mem_out,
  output logic              stall,
  output logic              done
);

  localparam int BEATS      = DATA_W / WORD_W;
  localparam int KW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_BYTES = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    READ_LAST = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [KW-1:0]     k_r;
  logic [KW-1:0]     k_nx_s;
  logic [KW-1:0]     last_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] beat_addr_s;
  logic [DATA_W-1:0] wbuf_r;
  logic [DATA_W-1:0] rbuf_r;
  logic [DATA_W-1:0] result_s;
  logic              vec_r;
  logic              req_s;
  logic              accept_s;

  assign req_s       = MemRead_in | MemWrite_in;
  assign accept_s    = (state_r == IDLE) && req_s;
  assign last_s      = vec_r ? KW'(BEATS - 1) : {KW{1'b0}};
  assign beat_addr_s = base_r + ADDR_W'(k_r) * ADDR_W'(WORD_BYTES);

  // Full vector result: buffered lanes 0..BEATS-2 plus the word arriving now.
  always_comb begin
    result_s = rbuf_r;
    result_s[DATA_W-1 -: WORD_W] = dm_rdata;
  end

  // Next-state, beat counter and memory/pipeline strobes decoded from state.
  always_comb begin
    state_nx_s = state_r;
    k_nx_s     = k_r;
    dm_addr    = {ADDR_W{1'b0}};
    dm_we      = 1'b0;
    dm_re      = 1'b0;
    dm_wdata   = {WORD_W{1'b0}};
    stall      = 1'b0;
    done       = 1'b0;
    case (state_r)
      IDLE: begin
        stall = rst & req_s;
        if (MemWrite_in) begin
          state_nx_s = WRITE;
          k_nx_s     = {KW{1'b0}};
        end else if (MemRead_in) begin
          state_nx_s = READ;
          k_nx_s     = {KW{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end
      WRITE: begin
        stall    = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = beat_addr_s;
        dm_wdata = wbuf_r[WORD_W*k_r +: WORD_W];
        k_nx_s   = k_r + KW'(1);
        if (k_r == last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WRITE;
        end
      end
      READ: begin
        stall   = 1'b1;
        dm_re   = 1'b1;
        dm_addr = beat_addr_s;
        k_nx_s  = k_r + KW'(1);
        if (k_r == last_s) begin
          state_nx_s = READ_LAST;
        end else begin
          state_nx_s = READ;
        end
      end
      READ_LAST: begin
        stall      = 1'b1;
        state_nx_s = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        k_nx_s     = {KW{1'b0}};
      end
    endcase
  end

  // State register; the pipeline segment registers also update on the falling edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      k_r     <= {KW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      k_r     <= k_nx_s;
    end
  end

  // Request latch at accept, and read-beat buffer (data trails dm_re by one cycle).
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      base_r <= {ADDR_W{1'b0}};
      wbuf_r <= {DATA_W{1'b0}};
      vec_r  <= 1'b0;
      rbuf_r <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        base_r <= addr_in & ~ADDR_W'(3);
        wbuf_r <= wdata_in;
        vec_r  <= VecOp_in;
      end
      if ((state_r == READ) && (k_r != {KW{1'b0}})) begin
        rbuf_r[WORD_W*(k_r - KW'(1)) +: WORD_W] <= dm_rdata;
      end
    end
  end

  // Result register changes only when a load finishes, so MEM/WB never sees a partial vector.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      mem_out <= {DATA_W{1'b0}};
    end else if (state_r == READ_LAST) begin
      mem_out <= vec_r ? result_s : DATA_W'(dm_rdata);
    end
  end

endmodule

// File: tb/tb_mem_vector_access.sv
// Randomized bench for mem_vector_access: per-transaction expected traces from a
// behavioural model, checked every cycle, plus directed literal expectations.
module tb_mem_vector_access;

  logic         clk = 1'b0;
  logic         rst;
  logic         MemRead_in, MemWrite_in, VecOp_in;
  logic [31:0]  addr_in;
  logic [191:0] wdata_in;
  logic [31:0]  dm_rdata = 32'h0;
  logic [31:0]  dm_addr;
  logic         dm_we, dm_re;
  logic [31:0]  dm_wdata;
  logic [191:0] mem_out;
  logic         stall, done;

  always #5 clk = ~clk;

  mem_vector_access dut (
    .clk(clk), .rst(rst), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .VecOp_in(VecOp_in), .addr_in(addr_in), .wdata_in(wdata_in), .dm_rdata(dm_rdata),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_re(dm_re), .dm_wdata(dm_wdata),
    .mem_out(mem_out), .stall(stall), .done(done)
  );

  typedef struct {
    logic         stall;
    logic         we;
    logic         re;
    logic         dn;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [191:0] mout;
  } exp_t;

  exp_t         expq[$];
  exp_t         cur_e;
  logic [31:0]  env_mem [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [31:0]  rd_log[$];
  logic [63:0]  wr_log[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           stall_cnt = 0;
  int           done_cnt = 0;
  bit           chk_en = 1'b0;
  logic [191:0] idle_mout = 192'h0;
  logic [191:0] ref_mout = 192'h0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic exp_t mk(input logic s, input logic w, input logic r, input logic d,
                              input logic [31:0] a, input logic [31:0] wd, input logic [191:0] mo);
    exp_t e;
    e.stall = s; e.we = w; e.re = r; e.dn = d; e.addr = a; e.wdata = wd; e.mout = mo;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous data memory: read data one cycle after dm_re, writes on dm_we.
  always @(negedge clk) begin
    if (dm_re) begin
      dm_rdata <= env_rd(dm_addr);
      rd_log.push_back(dm_addr);
    end
    if (dm_we) begin
      env_mem[dm_addr] = dm_wdata;
      wr_log.push_back({dm_addr, dm_wdata});
    end
  end

  // Per-cycle comparison against the model's expected trace (idle when empty).
  always @(posedge clk) begin
    if (chk_en) begin
      if (expq.size() > 0) cur_e = expq.pop_front();
      else cur_e = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, idle_mout);
      chk("stall", stall, cur_e.stall);
      chk("dm_we", dm_we, cur_e.we);
      chk("dm_re", dm_re, cur_e.re);
      chk("done", done, cur_e.dn);
      if (cur_e.we || cur_e.re) chk("dm_addr", dm_addr, cur_e.addr);
      if (cur_e.we) chk("dm_wdata", dm_wdata, cur_e.wdata);
      chk("mem_out", mem_out, cur_e.mout);
      if (cur_e.dn) idle_mout = cur_e.mout;
      if (stall) stall_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic rand_inputs();
    MemRead_in  = 1'($urandom);
    MemWrite_in = 1'($urandom);
    VecOp_in    = 1'($urandom);
    addr_in     = $urandom;
    wdata_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Called just after a falling edge; returns just after the falling edge ending DONE.
  task automatic run_txn(input bit w, input bit r, input bit v, input logic [31:0] a,
                         input logic [191:0] d, input bit scramble);
    int n;
    int len;
    logic [31:0]  base;
    logic [31:0]  ba;
    logic [191:0] nres;
    MemWrite_in = w; MemRead_in = r; VecOp_in = v; addr_in = a; wdata_in = d;
    base = a & 32'hFFFF_FFFC;
    n = v ? 6 : 1;
    expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ref_mout));
    if (w) begin
      for (int j = 0; j < n; j++) begin
        ba = base + 32'(4 * j);
        expq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, ba, d[32*j +: 32], ref_mout));
        ref_mem[ba] = d[32*j +: 32];
      end
      expq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, ref_mout));
      len = n + 2;
    end else begin
      nres = 192'h0;
      for (int j = 0; j < n; j++) begin
        ba = base + 32'(4 * j);
        expq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, ba, 32'h0, ref_mout));
        nres[32*j +: 32] = ref_rd(ba);
      end
      expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ref_mout));
      ref_mout = nres;
      expq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, ref_mout));
      len = n + 3;
    end
    for (int c = 1; c < len; c++) begin
      @(negedge clk); #1;
      if (scramble) rand_inputs();
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); #1;
      addr_in = $urandom; VecOp_in = 1'($urandom);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); stall_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    logic [191:0] vec_d;
    logic [191:0] lit;
    logic [31:0]  wrap_a [6];
    bit w, r;
    rst = 1'b0; MemRead_in = 1'b1; MemWrite_in = 1'b1; VecOp_in = 1'b1;
    addr_in = 32'h100; wdata_in = 192'h0;
    for (int k = 0; k < 6; k++) begin
      env_mem[32'h200 + 32'(4 * k)] = 32'h1111_1111 * 32'(k + 1);
      ref_mem[32'h200 + 32'(4 * k)] = 32'h1111_1111 * 32'(k + 1);
    end

    // reset state with a request present
    @(posedge clk);
    chk("rst_stall", stall, 1'b0); chk("rst_dm_we", dm_we, 1'b0); chk("rst_dm_re", dm_re, 1'b0);
    chk("rst_done", done, 1'b0); chk("rst_mem_out", mem_out, 192'h0);
    chk("rst_dm_addr", dm_addr, 32'h0); chk("rst_dm_wdata", dm_wdata, 32'h0);
    @(negedge clk); #1;
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    #2 rst = 1'b1;
    chk_en = 1'b1;

    // vector store at 0x100
    clear_logs();
    vec_d = {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run_txn(1'b1, 1'b0, 1'b1, 32'h100, vec_d, 1'b0);
    idle(2);
    chk("vst_writes", wr_log.size(), 6);
    for (int j = 0; j < 6 && j < wr_log.size(); j++)
      chk("vst_beat", wr_log[j], {32'h100 + 32'(4 * j), 32'hA0 + 32'(j)});
    chk("vst_stall_cycles", stall_cnt, 7);
    chk("vst_done_pulses", done_cnt, 1);

    // vector load at 0x200
    clear_logs();
    run_txn(1'b0, 1'b1, 1'b1, 32'h200, 192'h0, 1'b0);
    idle(1);
    lit = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    chk("vld_mem_out", mem_out, lit);
    chk("vld_reads", rd_log.size(), 6);
    chk("vld_stall_cycles", stall_cnt, 8);

    // misaligned scalar load
    clear_logs();
    run_txn(1'b0, 1'b1, 1'b0, 32'h203, 192'h0, 1'b0);
    idle(1);
    chk("sld_reads", rd_log.size(), 1);
    if (rd_log.size() > 0) chk("sld_addr", rd_log[0], 32'h200);
    chk("sld_mem_out", mem_out, 192'h1111_1111);
    chk("sld_stall_cycles", stall_cnt, 3);

    // read+write together, request held through DONE
    clear_logs();
    run_txn(1'b1, 1'b1, 1'b0, 32'h300, {6{32'hC0DE_0001}}, 1'b0);
    idle(2);
    chk("both_writes", wr_log.size(), 1);
    chk("both_reads", rd_log.size(), 0);
    chk("both_mem_out", mem_out, 192'h1111_1111);
    chk("both_stall_cycles", stall_cnt, 2);
    chk("both_done_pulses", done_cnt, 1);

    // wrap-around vector load
    clear_logs();
    run_txn(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 192'h0, 1'b0);
    idle(1);
    wrap_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
    chk("wrap_reads", rd_log.size(), 6);
    for (int j = 0; j < 6 && j < rd_log.size(); j++) chk("wrap_addr", rd_log[j], wrap_a[j]);

    // randomized traffic with inputs scrambled during each access
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        w = 1'($urandom); r = 1'($urandom);
        if (!w && !r) r = 1'b1;
        case ($urandom_range(0, 3))
          0: addr_in = $urandom;
          1: addr_in = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: addr_in = 32'h100 + 32'($urandom_range(0, 255));
        endcase
        run_txn(w, r, 1'($urandom), addr_in,
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
      end
    end
    idle(2);
    chk("model_queue_drained", expq.size(), 0);

    // reset in the middle of a vector store (beat 3)
    chk_en = 1'b0;
    wr_log.delete();
    MemWrite_in = 1'b1; MemRead_in = 1'b0; VecOp_in = 1'b1; addr_in = 32'h100;
    wdata_in = {32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
    repeat (4) @(negedge clk);
    @(posedge clk);
    chk("midrst_we_before", dm_we, 1'b1);
    chk("midrst_addr_before", dm_addr, 32'h10C);
    chk("midrst_wdata_before", dm_wdata, 32'hB3);
    #1 rst = 1'b0;
    #1;
    chk("midrst_dm_we", dm_we, 1'b0); chk("midrst_dm_re", dm_re, 1'b0);
    chk("midrst_stall", stall, 1'b0); chk("midrst_mem_out", mem_out, 192'h0);
    chk("midrst_done", done, 1'b0); chk("midrst_dm_addr", dm_addr, 32'h0);
    @(posedge clk);
    chk("midrst_stall_held", stall, 1'b0);
    @(negedge clk); #1;
    MemWrite_in = 1'b0;
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      chk("postrst_stall", stall, 1'b0); chk("postrst_dm_we", dm_we, 1'b0);
      chk("postrst_dm_re", dm_re, 1'b0); chk("postrst_done", done, 1'b0);
      chk("postrst_mem_out", mem_out, 192'h0);
    end
    chk("midrst_writes", wr_log.size(), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
